// File: rtl/tdm_demux.sv
// Two-channel serial TDM demultiplexer: sync strobe, then WIDTH A bits and WIDTH B bits, MSB first.
// Define TDM_PARITY_EN to add a trailing even-parity bit checked before the words are published.
module tdm_demux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] a_data,
  output logic [WIDTH-1:0] b_data,
  output logic             valid,
  output logic             frame_err
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef TDM_PARITY_EN
  typedef enum logic [1:0] {StIdle, StRxA, StRxB, StRxPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRxA, StRxB} state_e;
`endif

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  a_sr_q;
  logic [WIDTH-1:0]  b_sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      a_data    <= '0;
      b_data    <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sync) begin
            state_q <= StRxA;
            cnt_q   <= '0;
          end
        end

        StRxA: begin
          if (sync) begin
            // A stray sync restarts the frame; published words are untouched.
            frame_err <= 1'b1;
            cnt_q     <= '0;
          end else begin
            a_sr_q <= {a_sr_q[WIDTH-2:0], din};
            if (cnt_q == LastCnt) begin
              state_q <= StRxB;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end

`ifdef TDM_PARITY_EN
        StRxB: begin
          if (sync) begin
            frame_err <= 1'b1;
            state_q   <= StRxA;
            cnt_q     <= '0;
          end else begin
            b_sr_q <= {b_sr_q[WIDTH-2:0], din};
            if (cnt_q == LastCnt) begin
              state_q <= StRxPar;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end

        StRxPar: begin
          cnt_q <= '0;
          if (^{a_sr_q, b_sr_q, din} == 1'b0) begin
            a_data <= a_sr_q;
            b_data <= b_sr_q;
            valid  <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          // Sync on the closing edge starts the next frame with no gap.
          state_q <= sync ? StRxA : StIdle;
        end
`else
        StRxB: begin
          if (cnt_q == LastCnt) begin
            // Closing edge: the last B bit goes straight to the output register.
            b_sr_q  <= {b_sr_q[WIDTH-2:0], din};
            a_data  <= a_sr_q;
            b_data  <= {b_sr_q[WIDTH-2:0], din};
            valid   <= 1'b1;
            cnt_q   <= '0;
            state_q <= sync ? StRxA : StIdle;
          end else if (sync) begin
            frame_err <= 1'b1;
            state_q   <= StRxA;
            cnt_q     <= '0;
          end else begin
            b_sr_q <= {b_sr_q[WIDTH-2:0], din};
            cnt_q  <= cnt_q + CntW'(1);
          end
        end
`endif

        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (WIDTH=8): stimulus pushes expected pulses, a monitor pops them.
// Honours TDM_PARITY_EN when the design is built with it.
module tb_tdm_demux;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] a_data;
  logic [W-1:0] b_data;
  logic         valid;
  logic         frame_err;

  tdm_demux #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .sync      (sync),
    .a_data    (a_data),
    .b_data    (b_data),
    .valid     (valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         is_err;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int unsigned  cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic         done = 1'b0;
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic d);
    sync = s;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_err, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.is_err = is_err;
    e.a      = a;
    e.b      = b;
    e.cyc    = cyc;
    exp_q.push_back(e);
  endtask

  function automatic logic even_par(input logic [W-1:0] a, input logic [W-1:0] b);
    return ^{a, b};
  endfunction

  // Data bits of one frame (sync already sent); sync_last asserts sync on the closing edge.
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic par,
                            input logic sync_last, input logic ok);
    for (int i = W - 1; i >= 0; i--) drive(1'b0, a[i]);
`ifdef TDM_PARITY_EN
    for (int i = W - 1; i >= 0; i--) drive(1'b0, b[i]);
    drive(sync_last, par);
`else
    for (int i = W - 1; i > 0; i--) drive(1'b0, b[i]);
    drive(sync_last, b[0]);
`endif
    if (ok) begin
      push(1'b0, a, b);
      last_a = a;
      last_b = b;
    end else begin
      push(1'b1, last_a, last_b);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b0);

    // Basic frame
    drive(1'b1, 1'b0);
    send_frame(8'hA5, 8'h3C, even_par(8'hA5, 8'h3C), 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);

    // Back-to-back frames
    drive(1'b1, 1'b0);
    send_frame(8'h12, 8'h34, even_par(8'h12, 8'h34), 1'b1, 1'b1);
    send_frame(8'h56, 8'h78, even_par(8'h56, 8'h78), 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);

    // Abort after 5 A bits, then a full frame
    drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    push(1'b1, last_a, last_b);
    send_frame(8'hFF, 8'h00, even_par(8'hFF, 8'h00), 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);

    // Abort inside B
    drive(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    push(1'b1, last_a, last_b);
    send_frame(8'h81, 8'h7E, even_par(8'h81, 8'h7E), 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);

    // Reset mid-frame after 10 bits
    drive(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);
    #2 rst_n = 1'b0;
    last_a = '0;
    last_b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    send_frame(8'hC3, 8'h5A, even_par(8'hC3, 8'h5A), 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);

`ifdef TDM_PARITY_EN
    drive(1'b1, 1'b0);
    send_frame(8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    send_frame(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b0);
    // Bad parity with back-to-back sync still enters the next frame
    drive(1'b1, 1'b0);
    send_frame(8'h0F, 8'h01, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 8'h44, even_par(8'h22, 8'h44), 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);
`endif

    // Idle noise
    for (int i = 0; i < 50; i++) drive(1'b0, (i % 2) == 1);
    repeat (3) drive(1'b0, 1'b0);
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, got timeout required finish");
    $fatal(1);
  end

  // ---------------- monitor ----------------
  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  logic [W-1:0] mon_a = '0;
  logic [W-1:0] mon_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      mon_a = '0;
      mon_b = '0;
      chk("rst_a_data", 32'(a_data), 32'h0);
      chk("rst_b_data", 32'(b_data), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
    end else begin
      exp_t e;
      chk("valid_err_exclusive", 32'(valid & frame_err), 32'h0);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missing_pulse_cycle", cyc, e.cyc);
      end
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'h0, valid, frame_err}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_is_err", 32'(frame_err), 32'(e.is_err));
          chk("pulse_a_data", 32'(a_data), 32'(e.a));
          chk("pulse_b_data", 32'(b_data), 32'(e.b));
          if (!e.is_err) begin
            mon_a = e.a;
            mon_b = e.b;
          end
        end
      end else begin
        chk("hold_a_data", 32'(a_data), 32'(mon_a));
        chk("hold_b_data", 32'(b_data), 32'(mon_b));
      end
      if (done) begin
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter: WIDTH, default 8, bits per channel per frame (legal 2..16).
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: din  input  1  serial TDM data line, MSB-first per channel.
REQ-005 Port: sync  input  1  frame-start strobe, one cycle, precedes first data bit.
REQ-006 Port: a_data  output  WIDTH  last good channel-A word.
REQ-007 Port: b_data  output  WIDTH  last good channel-B word.
REQ-008 Port: valid  output  1  one-cycle pulse, a_data/b_data just updated.
REQ-009 Port: frame_err  output  1  one-cycle pulse, frame aborted or failed check.

Function
REQ-010 The FSM SHALL have the states IDLE, RX_A, RX_B and (macro only) RX_PAR.
- IDLE: waits for sync; din ignored.
REQ-011 On an edge sampling sync=1 in IDLE, the FSM SHALL go to RX_A with the bit counter at 0.
REQ-012 RX_A SHALL shift din into the A shift register on each of WIDTH edges, then go to RX_B.
REQ-013 RX_B SHALL shift din into the B shift register on each of WIDTH edges.
REQ-014 The counter SHALL be $clog2(WIDTH)+1 bits and SHALL reset to 0 on every state change.
REQ-015 Frame completion SHALL be the edge sampling the last B bit (parity bit with macro).
- On completion: a_data/b_data load the shift registers and valid pulses high for exactly the next cycle.
- Latency: sync edge + 2*WIDTH edges (+1 with macro).
REQ-016 After completion the FSM SHALL return to IDLE unless sync=1 on that same edge, in which case it SHALL enter RX_A directly (back-to-back frames, no gap cycle).
REQ-017 An edge sampling sync=1 at any other point in RX_A/RX_B/RX_PAR SHALL abort the frame.
- frame_err pulses one cycle.
- a_data/b_data and valid are unchanged.
- The FSM restarts in RX_A with the counter at 0.
REQ-018 a_data/b_data SHALL hold their value between completions and SHALL never expose partial shift data.
REQ-019 valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-020 rst_n low SHALL immediately force:
- FSM=IDLE, counter=0.
- Shift registers, a_data and b_data all 0.
- valid=0 and frame_err=0.
REQ-021 Reset during a frame SHALL discard the frame with no valid or frame_err pulse.
- After rst_n deasserts, the block waits for a fresh sync.

Configuration
REQ-022 Macro TDM_PARITY_EN SHALL compile in an even-parity bit after the B bits, sampled in RX_PAR.
- Good parity: XOR over all A bits, all B bits and the parity bit equals 0. The frame completes per REQ-015.
- Bad parity: outputs are not updated, valid stays 0 and frame_err pulses one cycle. REQ-016 still applies.
REQ-023 Without TDM_PARITY_EN the block SHALL have no RX_PAR state or parity logic, and a frame SHALL be exactly 2*WIDTH data bits.

Verification (WIDTH=8)
REQ-024 Basic frame: sync, then 0xA5 then 0x3C -> after 16 data edges a_data=0xA5, b_data=0x3C, valid high 1 cycle, frame_err=0.
REQ-025 Back-to-back: sync on the last-bit edge of frame 1, frames 0x12/0x34 then 0x56/0x78 -> two valid pulses 16 cycles apart with the correct data each.
REQ-026 Abort: sync again after 5 A bits, then a full 0xFF/0x00 frame -> frame_err pulse 1 cycle, then valid with a_data=0xFF, b_data=0x00.
REQ-027 Reset mid-frame: rst_n low after 10 bits -> all outputs 0 immediately, no pulses; the next complete frame decodes correctly.
REQ-028 Parity (TDM_PARITY_EN):
- 0x01/0x00 with parity bit 1 -> valid.
- Same frame with parity bit 0 -> frame_err, a_data/b_data unchanged.
REQ-029 Idle noise: toggle din with sync=0 for 50 cycles -> no valid, no frame_err, outputs unchanged.
